// File: rtl/dec_n_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input handshake.
// Output modes: LATCH (hold the line), PULSE (fixed-length strobe), SCAN (walk all lines).
// Optional feature macro: DEC_CNT_EN adds the CNT_W parameter and the saturating
// dec_count output that counts accepted transfers.
module dec_n_seq #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned PULSE_LEN = 4
`ifdef DEC_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      Din,
  output logic [2**SEL_W-1:0]   Dout,
  output logic                  out_valid,
  output logic                  busy
`ifdef DEC_CNT_EN
  ,
  output logic [CNT_W-1:0]      dec_count
`endif
);

  localparam int unsigned OUT_W   = 2**SEL_W;
  localparam int unsigned MAX_LEN = (PULSE_LEN > OUT_W) ? PULSE_LEN : OUT_W;
  localparam int unsigned TMR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Timer holds the number of cycles remaining after the current one.
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] SCAN_LOAD  = TMR_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] LINE0      = OUT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StPulse,
    StScan
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [OUT_W-1:0]   r_dout;
  logic [OUT_W-1:0]   w_dout_d;
  logic [TMR_W-1:0]   r_tmr;
  logic [TMR_W-1:0]   w_tmr_d;
  logic               w_accept;

  // Handshake: only IDLE/HOLD accept; reset forces not-ready.
  assign in_ready  = rst_n & en & ((r_state == StIdle) | (r_state == StHold));
  assign w_accept  = in_valid & in_ready;
  assign Dout      = r_dout;
  assign out_valid = |r_dout;
  assign busy      = (r_state == StPulse) | (r_state == StScan);

  // State, output line and sequence timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_dout  <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_dout  <= w_dout_d;
      r_tmr   <= w_tmr_d;
    end
  end

  // Next-state: disable wins, then accept, then sequence progress.
  always_comb begin
    w_state_d = r_state;
    w_dout_d  = r_dout;
    w_tmr_d   = r_tmr;
    if (!en) begin
      w_state_d = StIdle;
      w_dout_d  = '0;
      w_tmr_d   = '0;
    end else if (w_accept) begin
      w_dout_d = LINE0 << Din;
      unique case (mode)
        2'b01: begin
          w_state_d = StPulse;
          w_tmr_d   = PULSE_LOAD;
        end
        2'b10: begin
          w_state_d = StScan;
          w_tmr_d   = SCAN_LOAD;
        end
        default: begin
          w_state_d = StHold;
          w_tmr_d   = '0;
        end
      endcase
    end else begin
      unique case (r_state)
        StPulse: begin
          if (r_tmr == '0) begin
            w_state_d = StIdle;
            w_dout_d  = '0;
          end else begin
            w_tmr_d = r_tmr - 1'b1;
          end
        end
        StScan: begin
          if (r_tmr == '0) begin
            w_state_d = StIdle;
            w_dout_d  = '0;
          end else begin
            w_dout_d = {r_dout[OUT_W-2:0], r_dout[OUT_W-1]};
            w_tmr_d  = r_tmr - 1'b1;
          end
        end
        default: begin
          w_state_d = r_state;
        end
      endcase
    end
  end

`ifdef DEC_CNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating count of accepted transfers; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign dec_count = r_count;
`endif

endmodule

// File: tb/tb_dec_n_seq.sv
// Self-checking bench for dec_n_seq: directed table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dec_n_seq;

  localparam int unsigned PLEN0 = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Instance 0: SEL_W=2, PULSE_LEN=4.
  logic       en0 = 1'b0, vld0 = 1'b0, rdy0, ov0, busy0;
  logic [1:0] mode0 = '0, din0 = '0;
  logic [3:0] dout0;
  // Instance 1: SEL_W=3, PULSE_LEN=1.
  logic       en1 = 1'b0, vld1 = 1'b0, rdy1, ov1, busy1;
  logic [1:0] mode1 = '0;
  logic [2:0] din1 = '0;
  logic [7:0] dout1;
`ifdef DEC_CNT_EN
  logic [15:0] cnt0;
  logic [2:0]  cnt1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_n_seq #(
    .SEL_W(2),
    .PULSE_LEN(PLEN0)
`ifdef DEC_CNT_EN
    , .CNT_W(16)
`endif
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .in_valid(vld0), .in_ready(rdy0),
    .Din(din0), .Dout(dout0), .out_valid(ov0), .busy(busy0)
`ifdef DEC_CNT_EN
    , .dec_count(cnt0)
`endif
  );

  dec_n_seq #(
    .SEL_W(3),
    .PULSE_LEN(1)
`ifdef DEC_CNT_EN
    , .CNT_W(3)
`endif
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in_valid(vld1), .in_ready(rdy1),
    .Din(din1), .Dout(dout1), .out_valid(ov1), .busy(busy1)
`ifdef DEC_CNT_EN
    , .dec_count(cnt1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for instance 0: queue of upcoming Dout values for a timed
  // sequence, or a held line for LATCH.
  int unsigned mq[$];
  bit          m_hold;
  int unsigned m_hold_val;
  int unsigned m_cnt;
  bit          m_rdy;

  function automatic int unsigned m_dout();
    if (mq.size() != 0) return mq[0];
    return m_hold ? m_hold_val : 0;
  endfunction

  function automatic void m_clear();
    mq.delete();
    m_hold = 1'b0;
    m_hold_val = 0;
    m_cnt = 0;
  endfunction

  function automatic void m_edge(input bit e, input bit acc, input int m, input int d);
    if (!e) begin
      mq.delete();
      m_hold = 1'b0;
    end else if (acc) begin
      if (m_cnt < 65535) m_cnt++;
      mq.delete();
      m_hold = 1'b0;
      if (m == 1) begin
        for (int i = 0; i < PLEN0; i++) mq.push_back(1 << d);
      end else if (m == 2) begin
        for (int k = 0; k < 4; k++) mq.push_back(1 << ((d + k) % 4));
      end else begin
        m_hold = 1'b1;
        m_hold_val = 1 << d;
      end
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end
  endfunction

  // One cycle on instance 0: drive at negedge, sample ready, clock, settle.
  task automatic step0(input bit e, input bit v, input logic [1:0] m, input logic [1:0] d,
                       output bit rdy_seen);
    @(negedge clk);
    en0 = e; vld0 = v; mode0 = m; din0 = d;
    #1;
    rdy_seen = rdy0;
    m_rdy = e && (mq.size() == 0);
    @(posedge clk);
    m_edge(e, v && m_rdy, int'(m), int'(d));
    #1;
  endtask

  typedef struct {
    bit         e;
    bit         v;
    logic [1:0] m;
    logic [1:0] d;
    bit         rdy;
    logic [3:0] dout;
    bit         busy;
  } vec_t;

  vec_t tbl[20];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_clear();
  endtask

  initial begin
    bit r;
    string nm;

    // LATCH, back-to-back replace, PULSE with ignored valid, SCAN, SCAN aborted by en=0.
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 4'h4, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'h4, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd3, 2'd1, 1'b1, 4'h4, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 4'h8, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'd3, 2'd0, 1'b1, 4'h1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 4'h2, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 4'h2, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h2, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 4'h2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 2'd2, 2'd3, 1'b1, 4'h8, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h2, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h4, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 4'h1, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'h2, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 4'h0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 4'h0, 1'b0};

    // Reset state, with en high to show in_ready is held low by reset.
    en0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", int'(dout0), 0);
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_in_ready", int'(rdy0), 0);
`ifdef DEC_CNT_EN
    chk("reset_count", int'(cnt0), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();

    for (int i = 0; i < 20; i++) begin
      step0(tbl[i].e, tbl[i].v, tbl[i].m, tbl[i].d, r);
      $sformat(nm, "tbl%0d_in_ready", i);
      chk(nm, int'(r), int'(tbl[i].rdy));
      $sformat(nm, "tbl%0d_dout", i);
      chk(nm, int'(dout0), int'(tbl[i].dout));
      $sformat(nm, "tbl%0d_out_valid", i);
      chk(nm, int'(ov0), int'(tbl[i].dout != 0));
      $sformat(nm, "tbl%0d_busy", i);
      chk(nm, int'(busy0), int'(tbl[i].busy));
    end

    // LATCH held for 10 cycles.
    step0(1'b1, 1'b1, 2'd0, 2'd2, r);
    for (int i = 0; i < 10; i++) begin
      step0(1'b1, 1'b0, 2'd0, 2'd0, r);
      chk("latch_hold_dout", int'(dout0), 4);
    end

    // Reset asserted mid-PULSE clears immediately.
    step0(1'b1, 1'b1, 2'd1, 2'd3, r);
    step0(1'b1, 1'b0, 2'd0, 2'd0, r);
    chk("pre_rst_pulse_dout", int'(dout0), 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pulse_dout", int'(dout0), 0);
    chk("rst_mid_pulse_busy", int'(busy0), 0);
    chk("rst_mid_pulse_in_ready", int'(rdy0), 0);
`ifdef DEC_CNT_EN
    chk("rst_mid_pulse_count", int'(cnt0), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    step0(1'b1, 1'b0, 2'd0, 2'd0, r);
    chk("post_rst_idle_dout", int'(dout0), 0);
    chk("post_rst_idle_in_ready", int'(r), 1);

    // SEL_W=3 SCAN from 5 visits 5,6,7,0..4 then clears.
    @(negedge clk);
    en1 = 1'b1; vld1 = 1'b1; mode1 = 2'd2; din1 = 3'd5;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      vld1 = 1'b0;
      chk("scan8_dout", int'(dout1), 1 << ((5 + k) % 8));
      chk("scan8_busy", int'(busy1), 1);
      chk("scan8_in_ready", int'(rdy1), 0);
    end
    @(posedge clk);
    #1;
    chk("scan8_end_dout", int'(dout1), 0);
    chk("scan8_end_busy", int'(busy1), 0);
    chk("scan8_end_in_ready", int'(rdy1), 1);

    // PULSE_LEN=1: one-cycle strobe.
    vld1 = 1'b1; mode1 = 2'd1; din1 = 3'd6;
    @(posedge clk);
    #1;
    vld1 = 1'b0;
    chk("strobe_dout", int'(dout1), 8'h40);
    chk("strobe_busy", int'(busy1), 1);
    @(posedge clk);
    #1;
    chk("strobe_end_dout", int'(dout1), 0);
    chk("strobe_end_out_valid", int'(ov1), 0);

`ifdef DEC_CNT_EN
    chk("count1_two", int'(cnt1), 2);
    // Six back-to-back LATCH accepts: eight total saturates a 3-bit counter at 7.
    vld1 = 1'b1; mode1 = 2'd0;
    for (int i = 0; i < 6; i++) begin
      din1 = 3'(i);
      @(posedge clk);
      #1;
    end
    vld1 = 1'b0;
    chk("count1_saturate", int'(cnt1), 7);
`endif
    en1 = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit e, v;
      logic [1:0] m, d;
      bit exp_rdy;
      e = ($urandom_range(0, 15) != 0);
      v = ($urandom_range(0, 2) != 0);
      m = 2'($urandom_range(0, 3));
      d = 2'($urandom_range(0, 3));
      step0(e, v, m, d, r);
      exp_rdy = m_rdy;
      chk("rand_in_ready", int'(r), int'(exp_rdy));
      chk("rand_dout", int'(dout0), int'(m_dout()));
      chk("rand_out_valid", int'(ov0), int'(m_dout() != 0));
      chk("rand_busy", int'(busy0), int'(mq.size() != 0));
`ifdef DEC_CNT_EN
      chk("rand_count", int'(cnt0), int'(m_cnt));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
